// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, ALU codes
// and the controller state encoding.
package cpu_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_J     = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM_WAIT  = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of the latched instruction fields into an ALU code
// plus a flag saying whether the opcode/funct combination is supported.
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct_3,
  input  logic [6:0] func_7,
  output logic [3:0] alucontrol,
  output logic       valid
);

  // Opcode/funct lookup; anything not listed is flagged invalid
  always_comb begin
    alucontrol = ALU_ADD;
    valid      = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        case (funct_3)
          3'b000: begin
            // only R-type distinguishes ADD/SUB via func_7
            if (opcode == OP_I) begin
              alucontrol = ALU_ADD;
              valid      = 1'b1;
            end else if (func_7 == F7_ALT) begin
              alucontrol = ALU_SUB;
              valid      = 1'b1;
            end else if (func_7 == F7_BASE) begin
              alucontrol = ALU_ADD;
              valid      = 1'b1;
            end else begin
              alucontrol = ALU_ADD;
              valid      = 1'b0;
            end
          end
          3'b111: begin alucontrol = ALU_AND; valid = 1'b1; end
          3'b110: begin alucontrol = ALU_OR;  valid = 1'b1; end
          3'b100: begin alucontrol = ALU_XOR; valid = 1'b1; end
          3'b010: begin alucontrol = ALU_SLT; valid = 1'b1; end
          default: begin alucontrol = ALU_ADD; valid = 1'b0; end
        endcase
      end
      OP_LOAD, OP_STORE, OP_J: begin
        alucontrol = ALU_ADD;
        valid      = 1'b1;
      end
      OP_B: begin
        alucontrol = ALU_SUB;
        valid      = (funct_3 == 3'b000) || (funct_3 == 3'b001);
      end
      default: begin
        alucontrol = ALU_ADD;
        valid      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU controller: FETCH/DECODE/EXECUTE/MEM_WAIT/WRITEBACK FSM with
// a bounded memory wait and a sticky TRAP state for illegal ops and timeouts.
module multicycle_control_unit
  import cpu_pkg::*;
#(
  parameter int ALUCTRL_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct_3,
  input  logic [6:0]           func_7,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 instr_ready,
  output logic                 irwrite,
  output logic                 pcwrite,
  output logic                 regwrite,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 memtoreg,
  output logic                 alusrc,
  output logic                 branch_taken,
  output logic                 jump,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 busy,
  output logic                 illegal,
  output logic                 mem_fault
);

  state_e      state_r, state_s;
  logic [6:0]  opcode_r;
  logic [2:0]  funct3_r;
  logic [6:0]  funct7_r;
  logic [7:0]  mem_cnt_r;
  logic        illegal_r;
  logic        mem_fault_r;
  logic [3:0]  dec_alu_s;
  logic        dec_valid_s;
  logic        is_load_s;
  logic        timeout_s;

  alu_decoder u_alu_decoder (
    .opcode     (opcode_r),
    .funct_3    (funct3_r),
    .func_7     (funct7_r),
    .alucontrol (dec_alu_s),
    .valid      (dec_valid_s)
  );

  assign is_load_s = (opcode_r == OP_LOAD);
  // counter holds cycles already spent in MEM_WAIT, so the limit is hit on the last allowed cycle
  assign timeout_s = (mem_cnt_r == 8'(MEM_TIMEOUT - 1));
  assign illegal   = illegal_r;
  assign mem_fault = mem_fault_r;

  // Next-state and datapath strobe decode
  always_comb begin
    state_s      = state_r;
    instr_ready  = 1'b0;
    irwrite      = 1'b0;
    pcwrite      = 1'b0;
    regwrite     = 1'b0;
    memread      = 1'b0;
    memwrite     = 1'b0;
    memtoreg     = 1'b0;
    alusrc       = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    alucontrol   = {ALUCTRL_W{1'b0}};
    busy         = (state_r != FETCH);
    case (state_r)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid && !rst) begin
          irwrite = 1'b1;
          state_s = DECODE;
        end else begin
          state_s = FETCH;
        end
      end
      DECODE: begin
        if (dec_valid_s) begin
          state_s = EXECUTE;
        end else begin
          state_s = TRAP;
        end
      end
      EXECUTE: begin
        alucontrol = ALUCTRL_W'(dec_alu_s);
        case (opcode_r)
          OP_R: state_s = WRITEBACK;
          OP_I: begin
            alusrc  = 1'b1;
            state_s = WRITEBACK;
          end
          OP_LOAD, OP_STORE: begin
            alusrc  = 1'b1;
            state_s = MEM_WAIT;
          end
          OP_B: begin
            // PC is written either way: PC+4 when not taken, target when taken
            branch_taken = (funct3_r == 3'b000) ? zero : !zero;
            pcwrite      = 1'b1;
            state_s      = FETCH;
          end
          OP_J: begin
            jump     = 1'b1;
            regwrite = 1'b1;
            pcwrite  = 1'b1;
            state_s  = FETCH;
          end
          default: state_s = TRAP;
        endcase
      end
      MEM_WAIT: begin
        alucontrol = ALUCTRL_W'(ALU_ADD);
        alusrc     = 1'b1;
        memread    = is_load_s;
        memwrite   = !is_load_s;
        if (mem_ready) begin
          if (is_load_s) begin
            state_s = WRITEBACK;
          end else begin
            pcwrite = 1'b1;
            state_s = FETCH;
          end
        end else if (timeout_s) begin
          state_s = TRAP;
        end else begin
          state_s = MEM_WAIT;
        end
      end
      WRITEBACK: begin
        regwrite = 1'b1;
        pcwrite  = 1'b1;
        memtoreg = is_load_s;
        state_s  = FETCH;
      end
      TRAP:    state_s = TRAP;
      default: state_s = FETCH;
    endcase
  end

  // State, latched instruction fields, wait counter and sticky fault flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= FETCH;
      opcode_r    <= 7'd0;
      funct3_r    <= 3'd0;
      funct7_r    <= 7'd0;
      mem_cnt_r   <= 8'd0;
      illegal_r   <= 1'b0;
      mem_fault_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (irwrite) begin
        opcode_r <= opcode;
        funct3_r <= funct_3;
        funct7_r <= func_7;
      end else begin
        opcode_r <= opcode_r;
        funct3_r <= funct3_r;
        funct7_r <= funct7_r;
      end
      if (state_r == EXECUTE) begin
        mem_cnt_r <= 8'd0;
      end else if (state_r == MEM_WAIT) begin
        mem_cnt_r <= mem_cnt_r + 8'd1;
      end else begin
        mem_cnt_r <= mem_cnt_r;
      end
      if (state_r == DECODE && !dec_valid_s) begin
        illegal_r <= 1'b1;
      end else begin
        illegal_r <= illegal_r;
      end
      if (state_r == MEM_WAIT && state_s == TRAP) begin
        mem_fault_r <= 1'b1;
      end else begin
        mem_fault_r <= mem_fault_r;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit; strobes are
// compared as one vector each cycle, half a period after the rising edge.
module tb_multicycle_control_unit;

  localparam logic [12:0] S_IR    = 13'h1000;
  localparam logic [12:0] S_IRW   = 13'h0800;
  localparam logic [12:0] S_PCW   = 13'h0400;
  localparam logic [12:0] S_REGW  = 13'h0200;
  localparam logic [12:0] S_MR    = 13'h0100;
  localparam logic [12:0] S_MW    = 13'h0080;
  localparam logic [12:0] S_MTR   = 13'h0040;
  localparam logic [12:0] S_ASRC  = 13'h0020;
  localparam logic [12:0] S_BT    = 13'h0010;
  localparam logic [12:0] S_J     = 13'h0008;
  localparam logic [12:0] S_BUSY  = 13'h0004;
  localparam logic [12:0] S_ILL   = 13'h0002;
  localparam logic [12:0] S_MF    = 13'h0001;

  logic       clk = 1'b0;
  logic       rst, instr_valid, zero, mem_ready;
  logic [6:0] opcode, func_7;
  logic [2:0] funct_3;
  logic       instr_ready, irwrite, pcwrite, regwrite, memread, memwrite;
  logic       memtoreg, alusrc, branch_taken, jump, busy, illegal, mem_fault;
  logic [3:0] alucontrol;
  int         checks = 0;
  int         failures = 0;

  multicycle_control_unit #(.ALUCTRL_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .funct_3(funct_3), .func_7(func_7), .zero(zero), .mem_ready(mem_ready),
    .instr_ready(instr_ready), .irwrite(irwrite), .pcwrite(pcwrite),
    .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .alusrc(alusrc), .branch_taken(branch_taken),
    .jump(jump), .alucontrol(alucontrol), .busy(busy), .illegal(illegal),
    .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [12:0] evec, input logic [3:0] ealu);
    logic [12:0] ovec;
    ovec = {instr_ready, irwrite, pcwrite, regwrite, memread, memwrite, memtoreg,
            alusrc, branch_taken, jump, busy, illegal, mem_fault};
    checks++;
    assert (ovec === evec) else begin
      failures++;
      $error("FAIL %s strobes observed=%013b expected=%013b", tag, ovec, evec);
    end
    checks++;
    assert (alucontrol === ealu) else begin
      failures++;
      $error("FAIL %s alucontrol observed=%04b expected=%04b", tag, alucontrol, ealu);
    end
  endtask

  // one cycle: drive zero/mem_ready for this cycle, then check outputs
  task automatic cyc(input string tag, input logic z, input logic mr,
                     input logic [12:0] evec, input logic [3:0] ealu);
    @(negedge clk);
    zero = z;
    mem_ready = mr;
    #1;
    chk(tag, evec, ealu);
  endtask

  // accepting FETCH cycle then DECODE; fields are scrambled after acceptance
  task automatic accept(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7);
    @(negedge clk);
    instr_valid = 1'b1;
    opcode = op;
    funct_3 = f3;
    func_7 = f7;
    zero = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk({tag, "_fetch"}, S_IR | S_IRW, 4'd0);
    @(negedge clk);
    instr_valid = 1'b0;
    opcode = 7'b1111111;
    funct_3 = 3'b101;
    func_7 = 7'b1010101;
    #1;
    chk({tag, "_decode"}, S_BUSY, 4'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(tag, S_IR, 4'd0);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    opcode = 7'd0; funct_3 = 3'd0; func_7 = 7'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_idle", S_IR, 4'd0);
    cyc("idle_stay", 1'b0, 1'b0, S_IR, 4'd0);

    // R-type ADD: WB on cycle 3, FETCH on cycle 4
    accept("radd", 7'b0110011, 3'b000, 7'b0000000);
    cyc("radd_exec", 1'b0, 1'b0, S_BUSY, 4'b0000);
    cyc("radd_wb", 1'b0, 1'b0, S_BUSY | S_REGW | S_PCW, 4'd0);
    cyc("radd_fetch", 1'b0, 1'b0, S_IR, 4'd0);

    accept("rsub", 7'b0110011, 3'b000, 7'b0100000);
    cyc("rsub_exec", 1'b0, 1'b0, S_BUSY, 4'b0001);
    cyc("rsub_wb", 1'b0, 1'b0, S_BUSY | S_REGW | S_PCW, 4'd0);

    accept("rand", 7'b0110011, 3'b111, 7'b0000000);
    cyc("rand_exec", 1'b0, 1'b0, S_BUSY, 4'b0010);
    cyc("rand_wb", 1'b0, 1'b0, S_BUSY | S_REGW | S_PCW, 4'd0);

    // I-type ignores func_7
    accept("ixor", 7'b0010011, 3'b100, 7'b0100000);
    cyc("ixor_exec", 1'b0, 1'b0, S_BUSY | S_ASRC, 4'b0100);
    cyc("ixor_wb", 1'b0, 1'b0, S_BUSY | S_REGW | S_PCW, 4'd0);

    accept("islt", 7'b0010011, 3'b010, 7'b0000000);
    cyc("islt_exec", 1'b0, 1'b0, S_BUSY | S_ASRC, 4'b0101);
    cyc("islt_wb", 1'b0, 1'b0, S_BUSY | S_REGW | S_PCW, 4'd0);

    accept("beq_t", 7'b1100011, 3'b000, 7'b0000000);
    cyc("beq_t_exec", 1'b1, 1'b0, S_BUSY | S_PCW | S_BT, 4'b0001);
    cyc("beq_t_fetch", 1'b0, 1'b0, S_IR, 4'd0);

    accept("beq_n", 7'b1100011, 3'b000, 7'b0000000);
    cyc("beq_n_exec", 1'b0, 1'b0, S_BUSY | S_PCW, 4'b0001);
    cyc("beq_n_fetch", 1'b0, 1'b0, S_IR, 4'd0);

    accept("bne_t", 7'b1100011, 3'b001, 7'b0000000);
    cyc("bne_t_exec", 1'b0, 1'b0, S_BUSY | S_PCW | S_BT, 4'b0001);
    cyc("bne_t_fetch", 1'b0, 1'b0, S_IR, 4'd0);

    accept("jal", 7'b1101111, 3'b000, 7'b0000000);
    cyc("jal_exec", 1'b0, 1'b0, S_BUSY | S_J | S_REGW | S_PCW, 4'd0);
    cyc("jal_fetch", 1'b0, 1'b0, S_IR, 4'd0);

    // LOAD with mem_ready on the 3rd wait cycle
    accept("ld3", 7'b0000011, 3'b010, 7'b0000000);
    cyc("ld3_exec", 1'b0, 1'b0, S_BUSY | S_ASRC, 4'd0);
    cyc("ld3_mw1", 1'b0, 1'b0, S_BUSY | S_ASRC | S_MR, 4'd0);
    cyc("ld3_mw2", 1'b0, 1'b0, S_BUSY | S_ASRC | S_MR, 4'd0);
    cyc("ld3_mw3", 1'b0, 1'b1, S_BUSY | S_ASRC | S_MR, 4'd0);
    cyc("ld3_wb", 1'b0, 1'b0, S_BUSY | S_REGW | S_PCW | S_MTR, 4'd0);
    cyc("ld3_fetch", 1'b0, 1'b0, S_IR, 4'd0);

    // STORE completing on its first wait cycle
    accept("st1", 7'b0100011, 3'b010, 7'b0000000);
    cyc("st1_exec", 1'b0, 1'b0, S_BUSY | S_ASRC, 4'd0);
    cyc("st1_mw1", 1'b0, 1'b1, S_BUSY | S_ASRC | S_MW | S_PCW, 4'd0);
    cyc("st1_fetch", 1'b0, 1'b0, S_IR, 4'd0);

    // LOAD whose mem_ready arrives exactly on the limit cycle: no fault
    accept("ldlim", 7'b0000011, 3'b010, 7'b0000000);
    cyc("ldlim_exec", 1'b0, 1'b0, S_BUSY | S_ASRC, 4'd0);
    for (int i = 0; i < 15; i++) begin
      cyc("ldlim_mw", 1'b0, (i == 14), S_BUSY | S_ASRC | S_MR, 4'd0);
    end
    cyc("ldlim_wb", 1'b0, 1'b0, S_BUSY | S_REGW | S_PCW | S_MTR, 4'd0);
    cyc("ldlim_fetch", 1'b0, 1'b0, S_IR, 4'd0);

    // STORE never acknowledged: fault after 15 wait cycles, stuck in TRAP
    accept("sttmo", 7'b0100011, 3'b010, 7'b0000000);
    cyc("sttmo_exec", 1'b0, 1'b0, S_BUSY | S_ASRC, 4'd0);
    for (int i = 0; i < 15; i++) begin
      cyc("sttmo_mw", 1'b0, 1'b0, S_BUSY | S_ASRC | S_MW, 4'd0);
    end
    cyc("sttmo_trap", 1'b0, 1'b0, S_BUSY | S_MF, 4'd0);
    instr_valid = 1'b1;
    cyc("sttmo_trap_stay", 1'b0, 1'b1, S_BUSY | S_MF, 4'd0);
    cyc("sttmo_trap_stay2", 1'b0, 1'b0, S_BUSY | S_MF, 4'd0);
    do_reset("sttmo_after_rst");

    // Unsupported opcode
    accept("ill", 7'b1111111, 3'b000, 7'b0000000);
    cyc("ill_trap", 1'b0, 1'b0, S_BUSY | S_ILL, 4'd0);
    cyc("ill_trap_stay", 1'b0, 1'b0, S_BUSY | S_ILL, 4'd0);
    do_reset("ill_after_rst");

    // Bad funct combinations on supported opcodes also trap
    accept("rbad", 7'b0110011, 3'b000, 7'b0000001);
    cyc("rbad_trap", 1'b0, 1'b0, S_BUSY | S_ILL, 4'd0);
    do_reset("rbad_after_rst");
    accept("bbad", 7'b1100011, 3'b010, 7'b0000000);
    cyc("bbad_trap", 1'b0, 1'b0, S_BUSY | S_ILL, 4'd0);
    do_reset("bbad_after_rst");

    // Reset in the 2nd MEM_WAIT cycle of a LOAD abandons the access
    accept("ldrst", 7'b0000011, 3'b010, 7'b0000000);
    cyc("ldrst_exec", 1'b0, 1'b0, S_BUSY | S_ASRC, 4'd0);
    cyc("ldrst_mw1", 1'b0, 1'b0, S_BUSY | S_ASRC | S_MR, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ldrst_mw2", S_BUSY | S_ASRC | S_MR, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ldrst_after", S_IR, 4'd0);

    // Unit still works normally after the abandoned access
    accept("post", 7'b0110011, 3'b110, 7'b0000000);
    cyc("post_exec", 1'b0, 1'b0, S_BUSY, 4'b0011);
    cyc("post_wb", 1'b0, 1'b0, S_BUSY | S_REGW | S_PCW, 4'd0);
    cyc("post_fetch", 1'b0, 1'b0, S_IR, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 4, meaning width of alucontrol (minimum 3).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, meaning max cycles waiting on mem_ready before abort (1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 instr_valid  input  1  fetch port holds a valid instruction word this cycle.
REQ-006 opcode / funct_3 / func_7  input  7/3/7  instruction fields [6:0], [14:12], [31:25].
REQ-007 zero  input  1  ALU result-equal-zero flag, sampled in EXECUTE.
REQ-008 mem_ready  input  1  data memory completes the current access this cycle.
REQ-009 instr_ready  output  1  unit accepts instruction (high only in FETCH).
REQ-010 irwrite, pcwrite, regwrite, memread, memwrite, memtoreg, alusrc, branch_taken, jump  output  1 each  datapath strobes.
REQ-011 alucontrol  output  ALUCTRL_W  ALU op code.
REQ-012 busy / illegal / mem_fault  output  1 each  non-FETCH state / unsupported opcode seen / memory timeout.

Function
REQ-013 FSM states SHALL be FETCH, DECODE, EXECUTE, MEM_WAIT, WRITEBACK, TRAP.
REQ-014 FETCH: instr_ready=1; on instr_valid, irwrite=1 for that cycle, go DECODE; else stay.
REQ-015 DECODE: one cycle; supported opcodes R 0110011, I 0010011, LOAD 0000011, STORE 0100011, B 1100011, J 1101111 -> EXECUTE; any other -> TRAP.
REQ-016 EXECUTE: R/I -> WRITEBACK; LOAD/STORE -> MEM_WAIT; B/J -> FETCH with pcwrite=1 for that cycle.
REQ-017 ALU codes (zero-extended to ALUCTRL_W): ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101.
REQ-018 R-type: funct_3 000 with func_7 0100000 -> SUB, 000 with 0000000 -> ADD, 111 AND, 110 OR, 100 XOR, 010 SLT; other combos -> TRAP from DECODE.
REQ-019 I-type: same funct_3 mapping as R-type, func_7 ignored, funct_3 000 always ADD; alusrc=1.
REQ-020 LOAD/STORE: alucontrol=ADD, alusrc=1 in EXECUTE and MEM_WAIT.
REQ-021 B-type: alucontrol=SUB, alusrc=0; funct_3 000 (BEQ) taken when zero=1, 001 (BNE) taken when zero=0, other funct_3 -> TRAP; branch_taken=1 in EXECUTE cycle iff taken; pcwrite=1 regardless (PC+4 or target).
REQ-022 J-type: jump=1, regwrite=1, pcwrite=1 during EXECUTE cycle.
REQ-023 MEM_WAIT: memread (LOAD) or memwrite (STORE) held high every cycle; on mem_ready LOAD -> WRITEBACK, STORE -> FETCH with pcwrite=1 that cycle.
REQ-024 MEM_WAIT SHALL count cycles in an 8-bit counter cleared on entry; if mem_ready not seen after MEM_TIMEOUT cycles -> TRAP with mem_fault=1; mem_ready in the same cycle the limit is reached wins (no fault).
REQ-025 WRITEBACK: one cycle; regwrite=1, pcwrite=1, memtoreg=1 iff LOAD; -> FETCH.
REQ-026 TRAP: all strobes 0, busy=1, illegal or mem_fault held sticky; exits only via rst.
REQ-027 Opcode/funct fields SHALL be latched on irwrite; later state decisions use latched values only.
REQ-028 Every strobe not listed for a state SHALL be 0; latency: R/I 4 cycles, B/J 3 cycles, LOAD 4+N, STORE 3+N (N = MEM_WAIT cycles, >=1), counted from the accepting FETCH cycle.

Reset
REQ-029 rst SHALL force FETCH, counter=0, latched fields=0, illegal=mem_fault=0, all strobes 0, alucontrol=0, busy=0; rst wins over any simultaneous event including mid-MEM_WAIT (access abandoned, memread/memwrite low next cycle).

Structure
REQ-030 Opcode localparams, ALU code localparams and the state enum SHALL live in a shared package cpu_pkg.
REQ-031 Combinational ALU-code decode SHALL be a sub-module alu_decoder (opcode, funct_3, func_7 -> alucontrol, valid).

Verification
REQ-032 R-type ADD (0110011, 000, 0000000) with instr_valid -> irwrite cycle 0, alucontrol=0000 in EXECUTE, regwrite=1 cycle 3, back in FETCH cycle 4.
REQ-033 BEQ with zero=1 -> branch_taken=1, pcwrite=1 in EXECUTE; repeat with zero=0 -> branch_taken=0, pcwrite=1.
REQ-034 LOAD with mem_ready after 3 cycles -> memread high 3 cycles, WRITEBACK memtoreg=1 regwrite=1.
REQ-035 STORE with mem_ready never asserted, MEM_TIMEOUT=15 -> mem_fault=1 after 15 MEM_WAIT cycles, stuck in TRAP until rst.
REQ-036 Opcode 1111111 -> illegal=1 after DECODE, no strobes; rst asserted -> FETCH, illegal=0 next cycle.
REQ-037 rst asserted in 2nd MEM_WAIT cycle of a LOAD -> memread=0, instr_ready=1 next cycle.
